bp_stream_lock_arbiter: RTL and testbench
=========================================

# bp_stream_lock_arbiter

Round-robin arbiter that shares one BP Stream client port among `num_req_p` BP Stream masters, such as several BP Lite-to-Stream converters feeding one memory-side channel. A master that asserts its lock keeps the grant for every beat of its multi-beat message, so no other master can interleave beats into the message. The block sits between the converters and the downstream stream consumer. It adds no data latency: header and data pass through a mux selected by the current grant.

## Interface
- `num_req_p`, 2, number of requesters (≥1)
- `header_width_p`, "inv", stream header width in bits
- `data_width_p`, "inv", stream data beat width in bits
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `mem_header_i`  in  num_req_p*header_width_p  per-requester headers; requester i at slice i
- `mem_data_i`  in  num_req_p*data_width_p  per-requester data beats
- `mem_v_i`  in  num_req_p  per-requester beat valid
- `mem_lock_i`  in  num_req_p  per-requester hold request
- `mem_yumi_o`  out  num_req_p  per-requester beat accepted
- `mem_header_o`  out  header_width_p  granted header
- `mem_data_o`  out  data_width_p  granted data
- `mem_v_o`  out  1  granted valid
- `mem_yumi_i`  in  1  downstream accepts beat
- `mem_lock_o`  out  1  granted lock, forwarded downstream
- `grant_o`  out  `BSG_SAFE_CLOG2(num_req_p)`  current/candidate grant index, for debug and performance counters

## Operation
- States: `e_idle` and `e_locked`.
- Registers:
  - `state_r`
  - `grant_r` (held index)
  - `last_r` (round-robin pointer, the most recently served requester)
- **`e_idle`:**
  - Candidate `w` is the first requester with `mem_v_i` set, searching from `last_r+1` upward with wrap modulo `num_req_p`.
  - If no requester is valid: `mem_v_o=0`, `mem_lock_o=0`, and `grant_o=last_r`.
  - If a requester is valid: the outputs are driven from `w`, with `mem_lock_o = mem_lock_i[w]`.
  - If `mem_v_i[w] & mem_lock_i[w]`: `grant_r<=w`, `last_r<=w`, and the state moves to `e_locked`. This happens whether or not `mem_yumi_i` is asserted.
  - If `mem_v_i[w] & ~mem_lock_i[w] & mem_yumi_i` (single-beat message): `last_r<=w` and the state stays `e_idle`.
  - Lock without valid is ignored in `e_idle`.
- **`e_locked`:**
  - Outputs are driven from `grant_r`: `mem_v_o=mem_v_i[g]`, `mem_lock_o=mem_lock_i[g]`, `grant_o=grant_r`.
  - Other requesters are fully blocked.
  - `mem_v_i[g]=0` with the lock still high: the grant is held and `mem_v_o=0`.
  - `mem_lock_i[g]=0`: the state returns to `e_idle` next cycle.
  - If the lock drops in the same cycle as an accepted beat, that beat still completes.
- `mem_yumi_o[i] = mem_yumi_i & (i == selected index) & mem_v_o`; all other bits are 0.
- `mem_yumi_i` without `mem_v_o` is illegal (assertion).

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - `state_r=e_idle`, `grant_r=0`, `last_r=num_req_p-1`, so requester 0 has first priority.
  - While `reset_n_i=0`: `mem_v_o=0`, `mem_lock_o=0`, `mem_yumi_o=0`.
  - Reset mid-lock drops the grant immediately; masters are responsible for re-issuing.
- Header/data/valid paths are combinational: 0-cycle latency from input to output. The grant mux is combinational from registered state plus the idle-state priority pick.
- Arbitration takes 0 cycles in `e_idle`: the first beat can be accepted in the same cycle it is presented.
- Release costs 1 cycle: after the lock drops, a new winner can be served the following cycle.
- Fairness: every valid requester is served within `num_req_p-1` messages of other requesters.
- `num_req_p=1` gives a pass-through with state tracking only.

## Structure
- Shared package (`bp_me_pkg`): enum `bp_stream_arb_state_e {e_idle, e_locked}`.
- Sub-module `bp_stream_rr_pick`: combinational rotating priority encoder.
  - Inputs: `v_i`, `last_i`.
  - Outputs: `sel_o`, `sel_v_o`.
  - Implementation: rotate, priority-encode, un-rotate.
- The top module holds the FSM, the registers and the output muxes (`bsg_mux` by grant index).

## Test plan
- **Reset priority:** after reset, `v_i=2'b11`, `lock=0`, `yumi` every cycle. Grant order must be 0, 1, 0, 1; `yumi_o` is one-hot each cycle.
- **Locked 4-beat message:** requester 1 presents v+lock for 4 beats, lock low on beat 4, while requester 0 is valid throughout. All 4 beats come from requester 1; requester 0 is served on cycle 5 and `grant_o=1` for cycles 1–4.
- **Bubble in lock:** requester 0 is locked, `v_i[0]` drops for 2 cycles, and `v_i[1]=1`. `mem_v_o=0` on those cycles and requester 1 gets no `yumi`.
- **Back-pressure:** `mem_yumi_i=0` for 3 cycles with requester 0 locked. Header and data are stable, the grant holds, and there is no `yumi_o`.
- **Async reset mid-lock:** `reset_n_i` pulses low mid-cycle during a lock. Outputs go low immediately; after release, requester 0 is picked first.
- **Wrap-around with 3 requesters:** `last_r=2` and `v_i=3'b101`. Requester 0 is picked, then requester 2.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the BP stream arbitration slice.
package bp_me_pkg;

    typedef enum logic {
        e_idle,
        e_locked
    } bp_stream_arb_state_e;

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_stream_rr_pick.sv
// Combinational rotating priority encoder: first valid requester after last_i,
// wrapping modulo num_req_p.
module bp_stream_rr_pick
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p    = 2,
    localparam int unsigned sel_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    v_i,
    input  logic [sel_width_lp-1:0] last_i,
    output logic [sel_width_lp-1:0] sel_o,
    output logic                    sel_v_o
);

    logic [2*num_req_p-1:0] dbl;
    logic [num_req_p-1:0]   rot;
    int unsigned            start;
    int unsigned            idx;
    logic                   found;

    always_comb begin
        start = 32'(last_i) + 32'd1;
        if (start >= num_req_p) begin
            start = 0;
        end
        dbl = {v_i, v_i};
        // Rotation puts the requester right after last_i at bit 0.
        rot   = dbl[start +: num_req_p];
        found = 1'b0;
        idx   = 0;
        for (int unsigned j = 0; j < num_req_p; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        idx = idx + start;
        if (idx >= num_req_p) begin
            idx = idx - num_req_p;
        end
        sel_o   = sel_width_lp'(idx);
        sel_v_o = found;
    end

endmodule

// File: rtl/bp_stream_lock_arbiter.sv
// Round-robin arbiter sharing one BP stream port among num_req_p masters; a
// locked master keeps the grant for its whole multi-beat message.
module bp_stream_lock_arbiter
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p      = 2,
    parameter  int unsigned header_width_p = 8,
    parameter  int unsigned data_width_p   = 32,
    localparam int unsigned sel_width_lp   = safe_clog2(num_req_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p*header_width_p-1:0] mem_header_i,
    input  logic [num_req_p*data_width_p-1:0]   mem_data_i,
    input  logic [num_req_p-1:0]                mem_v_i,
    input  logic [num_req_p-1:0]                mem_lock_i,
    output logic [num_req_p-1:0]                mem_yumi_o,
    output logic [header_width_p-1:0]           mem_header_o,
    output logic [data_width_p-1:0]             mem_data_o,
    output logic                                mem_v_o,
    input  logic                                mem_yumi_i,
    output logic                                mem_lock_o,
    output logic [sel_width_lp-1:0]             grant_o
);

    localparam logic [sel_width_lp-1:0] LastRst = sel_width_lp'(num_req_p - 1);

    bp_stream_arb_state_e      state_q, state_d;
    logic [sel_width_lp-1:0]   grant_q, grant_d;
    logic [sel_width_lp-1:0]   last_q,  last_d;

    logic [sel_width_lp-1:0]   pick_sel;
    logic                      pick_v;
    logic [sel_width_lp-1:0]   sel_idx;
    logic                      v_raw;
    logic                      lock_raw;

    bp_stream_rr_pick #(
        .num_req_p (num_req_p)
    ) u_pick (
        .v_i     (mem_v_i),
        .last_i  (last_q),
        .sel_o   (pick_sel),
        .sel_v_o (pick_v)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            grant_q <= '0;
            last_q  <= LastRst;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            e_idle: begin
                if (pick_v && mem_lock_i[pick_sel]) begin
                    state_d = e_locked;
                    grant_d = pick_sel;
                    last_d  = pick_sel;
                end else if (pick_v && mem_yumi_i) begin
                    last_d  = pick_sel;
                end
            end
            e_locked: begin
                if (!mem_lock_i[grant_q]) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        sel_idx  = last_q;
        v_raw    = 1'b0;
        lock_raw = 1'b0;
        if (state_q == e_locked) begin
            sel_idx  = grant_q;
            v_raw    = mem_v_i[grant_q];
            lock_raw = mem_lock_i[grant_q];
        end else if (pick_v) begin
            sel_idx  = pick_sel;
            v_raw    = 1'b1;
            lock_raw = mem_lock_i[pick_sel];
        end

        mem_header_o = '0;
        mem_data_o   = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (sel_idx == sel_width_lp'(i)) begin
                mem_header_o = mem_header_i[i*header_width_p +: header_width_p];
                mem_data_o   = mem_data_i[i*data_width_p +: data_width_p];
            end
        end

        // Handshake outputs are forced quiet while reset is held.
        mem_v_o    = v_raw & reset_n_i;
        mem_lock_o = lock_raw & reset_n_i;
        grant_o    = sel_idx;
        mem_yumi_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            mem_yumi_o[i] = mem_yumi_i & mem_v_o & (sel_idx == sel_width_lp'(i));
        end
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_yumi_i |-> mem_v_o);

endmodule

// File: tb/tb_bp_stream_lock_arbiter.sv
// Self-checking bench for bp_stream_lock_arbiter: directed scenarios followed by
// randomized traffic, compared against a message-level reference model.
module tb_bp_stream_lock_arbiter;

    localparam int N  = 3;
    localparam int HW = 8;
    localparam int DW = 16;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*HW-1:0]   hdr_in;
    logic [N*DW-1:0]   dat_in;
    logic [N-1:0]      v_in;
    logic [N-1:0]      lock_in;
    logic              yumi_in;
    logic [N-1:0]      yumi_o;
    logic [HW-1:0]     hdr_o;
    logic [DW-1:0]     dat_o;
    logic              v_o;
    logic              lock_o;
    logic [SW-1:0]     grant_o;

    bp_stream_lock_arbiter #(
        .num_req_p      (N),
        .header_width_p (HW),
        .data_width_p   (DW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .mem_header_i (hdr_in),
        .mem_data_i   (dat_in),
        .mem_v_i      (v_in),
        .mem_lock_i   (lock_in),
        .mem_yumi_o   (yumi_o),
        .mem_header_o (hdr_o),
        .mem_data_o   (dat_o),
        .mem_v_o      (v_o),
        .mem_yumi_i   (yumi_in),
        .mem_lock_o   (lock_o),
        .grant_o      (grant_o)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: who owns the port and who was served most recently.
    bit m_locked;
    int m_owner;
    int m_last;

    bit          want_yumi;
    bit          e_v;
    bit          e_lock;
    int          e_grant;
    logic [HW-1:0] e_hdr;
    logic [DW-1:0] e_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_last   = N - 1;
    endtask

    task automatic compute_exp();
        bit found = 0;
        int w = 0;
        if (m_locked) begin
            e_grant = m_owner;
            e_v     = v_in[m_owner];
            e_lock  = lock_in[m_owner];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (!found && v_in[c]) begin
                    found = 1;
                    w = c;
                end
            end
            e_grant = found ? w : m_last;
            e_v     = found;
            e_lock  = found && lock_in[w];
        end
        e_hdr = hdr_in[e_grant*HW +: HW];
        e_dat = dat_in[e_grant*DW +: DW];
    endtask

    task automatic model_clock();
        if (m_locked) begin
            if (!lock_in[m_owner]) m_locked = 0;
        end else if (e_v) begin
            if (e_lock) begin
                m_locked = 1;
                m_owner  = e_grant;
                m_last   = e_grant;
            end else if (yumi_in) begin
                m_last = e_grant;
            end
        end
    endtask

    task automatic payload();
        for (int i = 0; i < N; i++) begin
            hdr_in[i*HW +: HW] = HW'($urandom);
            dat_in[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // One clock: compare combinational outputs mid-cycle, then advance model.
    // kg/ky are hand-derived grant / yumi_o values (-1 = unchecked).
    task automatic cycle(input string tag, input int kg, input int ky);
        logic [N-1:0] ey;
        compute_exp();
        yumi_in = want_yumi & e_v;
        ey = yumi_in ? N'(1 << e_grant) : '0;
        @(negedge clk);
        check({tag, "_v"},     32'(v_o),     32'(e_v));
        check({tag, "_lock"},  32'(lock_o),  32'(e_lock));
        check({tag, "_grant"}, 32'(grant_o), 32'(e_grant));
        check({tag, "_yumi"},  32'(yumi_o),  32'(ey));
        if (e_v) begin
            check({tag, "_hdr"}, 32'(hdr_o), 32'(e_hdr));
            check({tag, "_dat"}, 32'(dat_o), 32'(e_dat));
        end
        if (kg >= 0) check({tag, "_kgrant"}, 32'(grant_o), 32'(kg));
        if (ky >= 0) check({tag, "_kyumi"},  32'(yumi_o),  32'(ky));
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v_in = 3'b011; lock_in = '0; yumi_in = 1'b1; want_yumi = 1;
        payload();
        model_reset();
        #3;
        check("rst_v",    32'(v_o),    32'd0);
        check("rst_lock", 32'(lock_o), 32'd0);
        check("rst_yumi", 32'(yumi_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset priority: alternating service starting at requester 0.
        cycle("rr0", 0, 1); payload();
        cycle("rr1", 1, 2); payload();
        cycle("rr2", 0, 1); payload();
        cycle("rr3", 1, 2);

        // Wrap-around: put last on requester 2, then 3'b101 serves 0 then 2.
        v_in = 3'b100; payload();
        cycle("pre_wrap", 2, 4);
        v_in = 3'b101; payload();
        cycle("wrap0", 0, 1); payload();
        cycle("wrap1", 2, 4);

        // Locked 4-beat message from requester 1 while requester 0 waits.
        v_in = 3'b001; payload();
        cycle("pre_lock", 0, 1);
        v_in = 3'b011; lock_in = 3'b010;
        for (int b = 0; b < 3; b++) begin
            payload();
            cycle("lockmsg", 1, 2);
        end
        lock_in = 3'b000; payload();
        cycle("lockmsg_last", 1, 2);
        payload();
        cycle("after_lock", 0, 1);

        // Bubble: locked requester 0 drops valid, requester 1 must stay blocked.
        v_in = 3'b001; lock_in = 3'b001; payload();
        cycle("bub_start", 0, 1);
        v_in = 3'b010;
        cycle("bubble0", 0, 0);
        cycle("bubble1", 0, 0);
        v_in = 3'b011; lock_in = 3'b000; payload();
        cycle("bub_end", 0, 1);

        // Back-pressure on a locked requester: stable payload, no yumi.
        v_in = 3'b001; lock_in = 3'b001; want_yumi = 0; payload();
        for (int b = 0; b < 3; b++) cycle("bpress", 0, 0);
        v_in = 3'b011; lock_in = 3'b011; want_yumi = 1;
        cycle("bp_beat", 0, 1);

        // Asynchronous reset in the middle of the lock.
        #3;
        rst_n = 1'b0;
        yumi_in = 1'b0;
        #1;
        check("arst_v",    32'(v_o),    32'd0);
        check("arst_lock", 32'(lock_o), 32'd0);
        check("arst_yumi", 32'(yumi_o), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        v_in = 3'b011; lock_in = 3'b000; payload();
        cycle("post_arst", 0, 1);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            v_in = N'($urandom);
            lock_in = N'($urandom) & N'($urandom);
            want_yumi = ($urandom_range(0, 3) != 0);
            payload();
            cycle("rand", -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
